// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial, LSB-first subtractor computing a - b - bin modulo
//            2^WIDTH, plus the final unsigned borrow-out. One bit per clock.
//            The optional zero/ovf result flags exist only when the macro
//            SERIAL_SUB_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  // Counter is one bit wider than needed to index WIDTH bits, so it can
  // reach WIDTH after the final shift without ever wrapping.
  localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // r_a doubles as the result register: minuend bits leave at the bottom
  // while difference bits enter at the top.
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic               w_accept;
  logic               w_last;
  logic               w_ai;
  logic               w_bi;
  logic               w_d;
  logic               w_br_nxt;
  logic [WIDTH-1:0]   w_res;

  assign w_ai     = r_a[0];
  assign w_bi     = r_b[0];
  assign w_d      = w_ai ^ w_bi ^ r_br;
  assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last   = (r_cnt == c_LAST);
  assign w_res    = {w_d, r_a[WIDTH-1:1]};

  assign diff = r_diff;
  assign bout = r_bout;

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, status outputs and operand-accept decode.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch on accept, then one full-subtractor step per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a   <= w_res;
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_br  <= w_br_nxt;
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // Visible result updates only on the final shift edge and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_diff <= w_res;
      r_bout <= w_br_nxt;
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic r_zero;
  logic r_ovf;

  assign zero = r_zero;
  assign ovf  = r_ovf;

  // Flags track the result; on the final edge r_a[0]/r_b[0] hold the operand MSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_zero <= (w_res == '0) & ~w_br_nxt;
      r_ovf  <= (w_ai ^ w_bi) & (w_d ^ w_ai);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed self-checking bench for serial_subtractor (WIDTH=8 and
//            an exhaustive WIDTH=3 instance). Checks zero/ovf when built with
//            SERIAL_SUB_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // WIDTH=8 instance signals
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  // WIDTH=3 instance signals
  logic       t_start = 1'b0;
  logic [2:0] t_a = '0;
  logic [2:0] t_b = '0;
  logic       t_bin = 1'b0;
  logic       t_busy;
  logic       t_done;
  logic [2:0] t_diff;
  logic       t_bout;

`ifdef SERIAL_SUB_FLAGS_EN
  logic       zero;
  logic       ovf;
  logic       t_zero;
  logic       t_ovf;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] prev_diff = 8'h00;
  logic       prev_bout = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(3)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (t_start),
    .a     (t_a),
    .b     (t_b),
    .bin   (t_bin),
    .busy  (t_busy),
    .done  (t_done),
    .diff  (t_diff),
    .bout  (t_bout)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero  (t_zero),
    .ovf   (t_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a negedge sample with the DUT idle. Starts one
  // operation and checks busy/done timing, result hold and final result.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input logic [7:0] ed, input logic eb,
                        input logic ez, input logic eo, input string tag);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    bin   = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      chk({tag, " busy"}, busy, 1);
      chk({tag, " done_early"}, done, 0);
      chk({tag, " diff_hold"}, diff, prev_diff);
      chk({tag, " bout_hold"}, bout, prev_bout);
      @(negedge clk);
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " bout"}, bout, eb);
`ifdef SERIAL_SUB_FLAGS_EN
    chk({tag, " zero"}, zero, ez);
    chk({tag, " ovf"}, ovf, eo);
`else
    if (ez === 1'bx || eo === 1'bx) $display("note: unknown flag expectation in %s", tag);
`endif
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " diff_after"}, diff, ed);
    prev_diff = ed;
    prev_bout = eb;
  endtask

  initial begin
    logic [3:0] t_exp;

    // Reset state
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst diff", diff, 8'h00);
    chk("rst bout", bout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Start on the very first edge after reset release
    run_op(8'd5,  8'd3,  1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "5-3");
    run_op(8'd3,  8'd5,  1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "3-5");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, "80-1");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "0-0-1");
    run_op(8'h44, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "44-44");

    // start held high for 20 cycles with operands changing every cycle.
    // Accepts at cycles 0, 9 and 18; results: 0x10-0x00=0x10, 0x2B-0x09=0x22.
    for (int c = 0; c < 20; c++) begin
      start = 1'b1;
      a     = 8'h10 + 8'(3 * c);
      b     = 8'(c);
      bin   = 1'b0;
      @(negedge clk);
      chk("hold done", done, ((c == 8) || (c == 17)) ? 1 : 0);
      chk("hold busy", busy, ((c == 8) || (c == 17)) ? 0 : 1);
      if (c == 8) begin
        chk("hold diff1", diff, 8'h10);
        chk("hold bout1", bout, 0);
      end
      if (c == 17) begin
        chk("hold diff2", diff, 8'h22);
        chk("hold bout2", bout, 0);
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("drain busy", busy, 0);

    // Asynchronous reset four cycles into an operation
    start = 1'b1; a = 8'h55; b = 8'h11; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 8'h00);
    chk("abort bout", bout, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("abort no_done", done, 0);
      @(negedge clk);
    end
    prev_diff = 8'h00;
    prev_bout = 1'b0;
    run_op(8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, "after_rst");

    // WIDTH=3 exhaustive: {bout,diff} = a - b - bin
    for (int i = 0; i < 128; i++) begin
      t_a     = 3'(i >> 4);
      t_b     = 3'(i >> 1);
      t_bin   = 1'(i);
      t_start = 1'b1;
      t_exp   = {1'b0, t_a} - {1'b0, t_b} - {3'b000, t_bin};
      @(negedge clk);
      t_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("w3 done", t_done, 1);
      chk("w3 diff", t_diff, t_exp[2:0]);
      chk("w3 bout", t_bout, t_exp[3]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
